imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory with a little-endian byte-stream boot loader that holds the core in reset until loaded.
// Optional macro IMEM_LOADER_CHECKSUM_EN: the ld_last byte is an 8-bit checksum that must bring the byte sum to zero.
module imem_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RELEASE_DLY = 4,
  localparam int ADDR_W     = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  input  logic [DATA_WIDTH-1:0] InstrAddr,
  output logic [31:0]           Instr,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_W:0]       word_count
);

  // state | meaning
  // LOAD  | accepting program bytes, core held in reset
  // DELAY | stream done, counting down to core release
  // RUN   | core released, serving fetches
  // ERR   | overflow or bad checksum, core held in reset
  typedef enum logic [1:0] {S_LOAD, S_DELAY, S_RUN, S_ERR} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     asm_q, asm_d;
  logic [ADDR_W:0] word_count_q, word_count_d;
  logic [7:0]      dly_q, dly_d;
  logic            core_rst_n_q, core_rst_n_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  logic [31:0]     mem [DEPTH_WORDS];
  logic            accept;
  logic            do_write;
  logic            overflow;
  logic            wr_en;
  logic [31:0]     wr_data;
  logic [31:0]     merged;

  assign accept = ld_valid && (state_q == S_LOAD);
  assign merged = asm_q | ({24'h0, ld_data} << {idx_q, 3'b000});

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    dly_d        = dly_q;
    core_rst_n_d = core_rst_n_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    do_write     = 1'b0;
    overflow     = 1'b0;
    wr_en        = 1'b0;
    wr_data      = merged;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + ld_data;
          if (ld_last) begin
            // checksum byte itself is not payload; flush only what is assembled
            do_write = (idx_q != 2'd0);
            wr_data  = asm_q;
          end else begin
            do_write = (idx_q == 2'd3);
            idx_d    = idx_q + 2'd1;
            asm_d    = merged;
          end
`else
          do_write = (idx_q == 2'd3) || ld_last;
          idx_d    = idx_q + 2'd1;
          asm_d    = merged;
`endif
          if (do_write) begin
            if (word_count_q == (ADDR_W+1)'(DEPTH_WORDS)) begin
              overflow   = 1'b1;
              state_d    = S_ERR;
              load_err_d = 1'b1;
            end else begin
              wr_en        = 1'b1;
              word_count_d = word_count_q + 1'b1;
              asm_d        = '0;
              idx_d        = 2'd0;
            end
          end
          if (ld_last && !overflow) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (sum_d != 8'h00) begin
              state_d    = S_ERR;
              load_err_d = 1'b1;
            end else begin
              state_d = S_DELAY;
              dly_d   = 8'(RELEASE_DLY);
            end
`else
            state_d = S_DELAY;
            dly_d   = 8'(RELEASE_DLY);
`endif
          end
        end
      end
      S_DELAY: begin
        if (dly_q <= 8'd1) begin
          dly_d        = 8'd0;
          state_d      = S_RUN;
          core_rst_n_d = 1'b1;
          load_done_d  = 1'b1;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      idx_q        <= 2'd0;
      asm_q        <= '0;
      word_count_q <= '0;
      dly_q        <= 8'd0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      dly_q        <= dly_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // RAM is not reset; stale words stay hidden behind word_count
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_count_q[ADDR_W-1:0]] <= wr_data;
  end

  logic [ADDR_W-1:0] rd_idx;
  logic              rd_oor;
  logic              unused_addr_lsb;

  assign rd_idx          = InstrAddr[ADDR_W+1:2];
  assign rd_oor          = |InstrAddr[DATA_WIDTH-1:ADDR_W+2];
  assign unused_addr_lsb = ^InstrAddr[1:0];

  always_comb begin
    Instr = NOP;
    if (core_rst_n_q && !rd_oor && ({1'b0, rd_idx} < word_count_q)) Instr = mem[rd_idx];
  end

  assign ld_ready   = (state_q == S_LOAD);
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (DEPTH_WORDS=4, RELEASE_DLY=4).
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the checksum variant instead of the plain loads.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic [31:0] InstrAddr;
  logic [31:0] Instr;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;
  logic [2:0]  word_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  imem_loader #(.DATA_WIDTH(32), .DEPTH_WORDS(4), .RELEASE_DLY(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .InstrAddr(InstrAddr), .Instr(Instr),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    ld_valid = 1'b1; ld_data = d; ld_last = l;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    InstrAddr = 32'h0;
    rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total_cnt++; if (ld_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", ld_ready); else pass_cnt++;
    total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL rst_core_rst_n got %b exp 0", core_rst_n); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b0) $display("FAIL rst_done got %b exp 0", load_done); else pass_cnt++;
    total_cnt++; if (load_err !== 1'b0) $display("FAIL rst_err got %b exp 0", load_err); else pass_cnt++;
    total_cnt++; if (word_count !== 3'd0) $display("FAIL rst_wc got %0d exp 0", word_count); else pass_cnt++;
    total_cnt++; if (Instr !== 32'h13) $display("FAIL rst_instr got %h exp 00000013", Instr); else pass_cnt++;
  endtask

  task automatic test_load();
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
    total_cnt++; if (word_count !== 3'd2) $display("FAIL load_wc got %0d exp 2", word_count); else pass_cnt++;
    total_cnt++; if (ld_ready !== 1'b0) $display("FAIL load_delay_ready got %b exp 0", ld_ready); else pass_cnt++;
    wait_cycles(3);
    total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL load_early_release got %b exp 0", core_rst_n); else pass_cnt++;
    total_cnt++; if (Instr !== 32'h13) $display("FAIL load_instr_held got %h exp 00000013", Instr); else pass_cnt++;
    wait_cycles(1);
    total_cnt++; if (core_rst_n !== 1'b1) $display("FAIL load_release got %b exp 1", core_rst_n); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b1) $display("FAIL load_done got %b exp 1", load_done); else pass_cnt++;
    InstrAddr = 32'h0; #1;
    total_cnt++; if (Instr !== 32'h00A00513) $display("FAIL load_instr0 got %h exp 00a00513", Instr); else pass_cnt++;
    InstrAddr = 32'h4; #1;
    total_cnt++; if (Instr !== 32'h00100593) $display("FAIL load_instr4 got %h exp 00100593", Instr); else pass_cnt++;
    InstrAddr = 32'h8; #1;
    total_cnt++; if (Instr !== 32'h00000013) $display("FAIL load_instr8 got %h exp 00000013", Instr); else pass_cnt++;
  endtask

  task automatic test_run_backpressure();
    ld_valid = 1'b1; ld_data = 8'hFF; ld_last = 1'b1;
    #1;
    total_cnt++; if (ld_ready !== 1'b0) $display("FAIL run_ready got %b exp 0", ld_ready); else pass_cnt++;
    wait_cycles(3);
    ld_valid = 1'b0; ld_last = 1'b0;
    total_cnt++; if (word_count !== 3'd2) $display("FAIL run_wc got %0d exp 2", word_count); else pass_cnt++;
    InstrAddr = 32'h0; #1;
    total_cnt++; if (Instr !== 32'h00A00513) $display("FAIL run_instr0 got %h exp 00a00513", Instr); else pass_cnt++;
  endtask

  task automatic test_partial();
    logic [7:0] prog [6];
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(prog[i], i == 5);
    total_cnt++; if (word_count !== 3'd2) $display("FAIL part_wc got %0d exp 2", word_count); else pass_cnt++;
    wait_cycles(4);
    InstrAddr = 32'h0; #1;
    total_cnt++; if (Instr !== 32'h44332211) $display("FAIL part_instr0 got %h exp 44332211", Instr); else pass_cnt++;
    InstrAddr = 32'h6; #1;
    total_cnt++; if (Instr !== 32'h00006655) $display("FAIL part_instr6 got %h exp 00006655", Instr); else pass_cnt++;
    InstrAddr = 32'h8; #1;
    total_cnt++; if (Instr !== 32'h00000013) $display("FAIL part_instr8 got %h exp 00000013", Instr); else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    total_cnt++; if (word_count !== 3'd4) $display("FAIL full_wc got %0d exp 4", word_count); else pass_cnt++;
    total_cnt++; if (load_err !== 1'b0) $display("FAIL full_err got %b exp 0", load_err); else pass_cnt++;
    wait_cycles(4);
    InstrAddr = 32'hC; #1;
    total_cnt++; if (Instr !== 32'h0F0E0D0C) $display("FAIL full_instrC got %h exp 0f0e0d0c", Instr); else pass_cnt++;
    InstrAddr = 32'h10; #1;
    total_cnt++; if (Instr !== 32'h00000013) $display("FAIL full_instr10 got %h exp 00000013", Instr); else pass_cnt++;
    InstrAddr = 32'hFFFF_FFF4; #1;
    total_cnt++; if (Instr !== 32'h00000013) $display("FAIL full_instr_hi got %h exp 00000013", Instr); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 19; i++) send_byte(8'(8'h40 + i), 1'b0);
    total_cnt++; if (load_err !== 1'b0) $display("FAIL ovf_early_err got %b exp 0", load_err); else pass_cnt++;
    total_cnt++; if (word_count !== 3'd4) $display("FAIL ovf_wc got %0d exp 4", word_count); else pass_cnt++;
    send_byte(8'h53, 1'b0);
    total_cnt++; if (load_err !== 1'b1) $display("FAIL ovf_err got %b exp 1", load_err); else pass_cnt++;
    total_cnt++; if (ld_ready !== 1'b0) $display("FAIL ovf_ready got %b exp 0", ld_ready); else pass_cnt++;
    wait_cycles(6);
    total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL ovf_core_rst_n got %b exp 0", core_rst_n); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b0) $display("FAIL ovf_done got %b exp 0", load_done); else pass_cnt++;
    InstrAddr = 32'h0; #1;
    total_cnt++; if (Instr !== 32'h00000013) $display("FAIL ovf_instr got %h exp 00000013", Instr); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i), 1'b0);
    do_reset();
    total_cnt++; if (word_count !== 3'd0) $display("FAIL mid_wc_clr got %0d exp 0", word_count); else pass_cnt++;
    total_cnt++; if (ld_ready !== 1'b1) $display("FAIL mid_ready got %b exp 1", ld_ready); else pass_cnt++;
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b1);
    total_cnt++; if (word_count !== 3'd1) $display("FAIL mid_wc got %0d exp 1", word_count); else pass_cnt++;
    total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL mid_pre_release got %b exp 0", core_rst_n); else pass_cnt++;
    wait_cycles(4);
    InstrAddr = 32'h0; #1;
    total_cnt++; if (Instr !== 32'hDDCCBBAA) $display("FAIL mid_instr0 got %h exp ddccbbaa", Instr); else pass_cnt++;
    InstrAddr = 32'h4; #1;
    total_cnt++; if (Instr !== 32'h00000013) $display("FAIL mid_stale_hidden got %h exp 00000013", Instr); else pass_cnt++;
    do_reset();
    total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL run_reset_core got %b exp 0", core_rst_n); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b0) $display("FAIL run_reset_done got %b exp 0", load_done); else pass_cnt++;
  endtask

  task automatic test_checksum();
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hF6, 1'b1);
    total_cnt++; if (word_count !== 3'd1) $display("FAIL cks_wc got %0d exp 1", word_count); else pass_cnt++;
    wait_cycles(4);
    total_cnt++; if (core_rst_n !== 1'b1) $display("FAIL cks_release got %b exp 1", core_rst_n); else pass_cnt++;
    InstrAddr = 32'h0; #1;
    total_cnt++; if (Instr !== 32'h04030201) $display("FAIL cks_instr0 got %h exp 04030201", Instr); else pass_cnt++;
    InstrAddr = 32'h4; #1;
    total_cnt++; if (Instr !== 32'h00000013) $display("FAIL cks_instr4 got %h exp 00000013", Instr); else pass_cnt++;
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hF5, 1'b1);
    total_cnt++; if (load_err !== 1'b1) $display("FAIL cks_bad_err got %b exp 1", load_err); else pass_cnt++;
    wait_cycles(6);
    total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL cks_bad_core got %b exp 0", core_rst_n); else pass_cnt++;
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'hFA, 1'b1);
    total_cnt++; if (word_count !== 3'd1) $display("FAIL cks_part_wc got %0d exp 1", word_count); else pass_cnt++;
    wait_cycles(4);
    InstrAddr = 32'h0; #1;
    total_cnt++; if (Instr !== 32'h00030201) $display("FAIL cks_part_instr got %h exp 00030201", Instr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_load();
    test_run_backpressure();
    test_partial();
    test_full();
    test_overflow();
    test_mid_reset();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
